// File: rtl/lfsr_stim_gen_if.sv
// Control and write-side bus for the LFSR stimulus generator.
// The master drives burst control and the FIFO full flag. The slave (the generator) drives the write strobe and data.
interface lfsr_stim_gen_if #(
    parameter int DATA_W = 8,
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_words;
    logic              seed_ld;
    logic [LFSR_W-1:0] seed_in;
    logic              full;
    logic              wr;
    logic [DATA_W-1:0] d_out;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, num_words, seed_ld, seed_in, full,
        input  wr, d_out, word_cnt, busy, done
    );

    modport slave (
        input  start, abort, num_words, seed_ld, seed_in, full,
        output wr, d_out, word_cnt, busy, done
    );
endinterface

// File: rtl/lfsr_stim_gen.sv
// Galois-LFSR stimulus generator for a FIFO write port. It supports burst, free-run and abort, and the strobe honours full.
// Define RNG_LOG_EN to print every written word, in decimal, to the simulator transcript (simulation only).
module lfsr_stim_gen #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'h0AA1,
    parameter int                CNT_W  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    lfsr_stim_gen_if.slave gen_if
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LFSR_W-1:0] LFSR_ONE = LFSR_W'(1);

    state_e            state_q;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, nwords_q;
    logic              busy_q, done_q;
    logic              wr;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] nz(input logic [LFSR_W-1:0] v);
        return (v == '0) ? LFSR_ONE : v;
    endfunction

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end

    assign wr              = (state_q == S_RUN) && !gen_if.full && !gen_if.abort;
    assign gen_if.wr       = wr;
    assign gen_if.d_out    = lfsr_q[DATA_W-1:0];
    assign gen_if.word_cnt = cnt_q;
    assign gen_if.busy     = busy_q;
    assign gen_if.done     = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lfsr_q   <= nz(SEED);
            cnt_q    <= '0;
            nwords_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    // The seed load and start may share a cycle, so the burst begins at the new seed.
                    if (gen_if.seed_ld) lfsr_q <= nz(gen_if.seed_in);
                    if (gen_if.start) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        nwords_q <= gen_if.num_words;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (gen_if.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!gen_if.full) begin
                        lfsr_q <= lfsr_d;
                        cnt_q  <= cnt_q + CNT_ONE;
                        // A latched count of zero means free-run. Only abort leaves that mode.
                        if (nwords_q != '0 && cnt_q == nwords_q - CNT_ONE) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RNG_LOG_EN
    always @(posedge clk_i) begin
        if (wr) $display("%0d", gen_if.d_out);
    end
`endif
endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Directed bench for lfsr_stim_gen at DATA_W=16. Expected words are queued when a burst is launched and checked as wr fires.
module tb_lfsr_stim_gen;
    localparam int DW = 16;
    localparam int LW = 16;
    localparam int CW = 16;
    localparam logic [LW-1:0] TAPS = 16'hB400;
    localparam logic [LW-1:0] SEED = 16'h0AA1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_seen  = 0;
    logic [DW-1:0] sb[$];

    lfsr_stim_gen_if #(.DATA_W(DW), .LFSR_W(LW), .CNT_W(CW)) bus ();

    lfsr_stim_gen #(.DATA_W(DW), .LFSR_W(LW), .TAPS(TAPS), .SEED(SEED), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .gen_if(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] step(input logic [LW-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Scoreboard: every write must carry the next queued word.
    always @(negedge clk) begin
        logic [DW-1:0] exp;
        if (!rst && bus.wr) begin
            exp = 'x;
            if (sb.size() > 0) exp = sb.pop_front();
            wr_seen++;
            chk("sb_word", 32'(bus.d_out), 32'(exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_burst(input logic [CW-1:0] n);
        bus.num_words = n;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!bus.done && k < lim) begin
            tick();
            k++;
        end
        chk("done_wait", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int w0;
        int done_seen;
        int saw_zero;
        logic [LW-1:0] s;
        bus.start = 0; bus.abort = 0; bus.num_words = '0;
        bus.seed_ld = 0; bus.seed_in = '0; bus.full = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_wr",    32'(bus.wr),       32'd0);
        chk("rst_dout",  32'(bus.d_out),    32'h0AA1);
        chk("rst_cnt",   32'(bus.word_cnt), 32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);

        // Basic 4-word burst, one word per cycle from the cycle after start
        sb.push_back(16'h0AA1); sb.push_back(16'hB150);
        sb.push_back(16'h58A8); sb.push_back(16'h2C54);
        w0 = wr_seen;
        start_burst(4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_wr", 32'(bus.wr), 32'd1);
            chk("burst_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("burst_done", 32'(bus.done),     32'd1);
        chk("burst_busy_lo", 32'(bus.busy),  32'd0);
        chk("burst_cnt",  32'(bus.word_cnt), 32'd4);
        chk("burst_wr_lo", 32'(bus.wr),      32'd0);
        chk("burst_nwr",  32'(wr_seen - w0), 32'd4);

        // Same burst with a 3-cycle full stall after the second word
        do_reset();
        sb.push_back(16'h0AA1); sb.push_back(16'hB150);
        sb.push_back(16'h58A8); sb.push_back(16'h2C54);
        w0 = wr_seen;
        start_burst(4);
        tick(); tick();
        bus.full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wr",   32'(bus.wr),    32'd0);
            chk("stall_dout", 32'(bus.d_out), 32'h58A8);
            tick();
        end
        chk("stall_cnt", 32'(bus.word_cnt), 32'd2);
        bus.full = 1'b0;
        wait_done(10);
        chk("stall_nwr", 32'(wr_seen - w0), 32'd4);

        // Seed load together with start from DONE
        sb.push_back(16'h0001); sb.push_back(16'hB400); sb.push_back(16'h5A00);
        w0 = wr_seen;
        bus.seed_ld = 1'b1; bus.seed_in = 16'h0001;
        start_burst(3);
        bus.seed_ld = 1'b0;
        wait_done(10);
        chk("seed_nwr", 32'(wr_seen - w0), 32'd3);
        chk("seed_cnt", 32'(bus.word_cnt), 32'd3);

        // Zero seed is guarded to 1
        bus.seed_ld = 1'b1; bus.seed_in = 16'h0000;
        tick();
        bus.seed_ld = 1'b0;
        chk("zseed_dout", 32'(bus.d_out), 32'h0001);
        chk("zseed_busy", 32'(bus.busy),  32'd0);

        // Free-run past the counter wrap, then abort
        do_reset();
        s = SEED;
        for (int i = 0; i < 70000; i++) begin
            sb.push_back(s[DW-1:0]);
            s = step(s);
        end
        w0 = wr_seen;
        done_seen = 0;
        saw_zero  = 0;
        start_burst(0);
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (bus.done) done_seen = 1;
            if (bus.word_cnt == '0) saw_zero = 1;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_wr", 32'(bus.wr), 32'd0);
        tick();
        bus.abort = 1'b0;
        chk("free_done_never", 32'(done_seen), 32'd0);
        chk("free_wrap",  32'(saw_zero),     32'd1);
        chk("free_nwr",   32'(wr_seen - w0), 32'd70000);
        chk("abort_cnt",  32'(bus.word_cnt), 32'd4464);
        chk("abort_busy", 32'(bus.busy),     32'd0);
        chk("abort_done", 32'(bus.done),     32'd0);
        chk("abort_idle_wr", 32'(bus.wr),    32'd0);

        // Reset mid-burst after two words, with a competing start
        sb.push_back(16'h0AA1); sb.push_back(16'hB150);
        do_reset();
        start_burst(4);
        tick(); tick();
        rst = 1'b1; bus.start = 1'b1; bus.num_words = 16'd4;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        chk("mrst_dout", 32'(bus.d_out),    32'h0AA1);
        chk("mrst_cnt",  32'(bus.word_cnt), 32'd0);
        chk("mrst_busy", 32'(bus.busy),     32'd0);
        chk("mrst_wr",   32'(bus.wr),       32'd0);
        chk("mrst_done", 32'(bus.done),     32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
